// File: rtl/debounce_sync_rstl_pkg.sv
// Shared debouncer definitions: 2-bit state encodings and default sizing.
// The rise/fall edge pulses are built only when DEBOUNCE_EDGE_EN is defined.
`ifndef DEBOUNCE_DEFS_VH
`define DEBOUNCE_DEFS_VH
`define DEB_IDLE_LO 2'd0
`define DEB_WAIT_HI 2'd1
`define DEB_IDLE_HI 2'd2
`define DEB_WAIT_LO 2'd3
`endif

package debounce_sync_rstl_pkg;

    localparam int DEF_STABLE_CNT = 50000;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE_LO = `DEB_IDLE_LO,
        WAIT_HI = `DEB_WAIT_HI,
        IDLE_HI = `DEB_IDLE_HI,
        WAIT_LO = `DEB_WAIT_LO
    } state_e;

endpackage

// File: rtl/debounce_sync_rstl_sync.sv
// Two-flop synchronizer with synchronous active-low reset to RST_VAL.
module sync_2ff_rstl #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/debounce_sync_rstl.sv
// Debouncer: synchronizer, stability counter and 4-state FSM producing a clean level,
// a busy flag and (with DEBOUNCE_EDGE_EN defined) one-cycle rise/fall pulses.
module debounce_sync_rstl
    import debounce_sync_rstl_pkg::*;
#(
    parameter int   CNT_W      = DEF_CNT_W,
    parameter int   STABLE_CNT = DEF_STABLE_CNT,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CNT - 1);
    localparam state_e           RESET_STATE = RST_VAL ? IDLE_HI : IDLE_LO;

    logic             s2;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             commitHi;
    logic             commitLo;

    sync_2ff_rstl #(
        .RST_VAL(RST_VAL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (din),
        .q  (s2)
    );

    assign commitHi = (state_q == WAIT_HI) && s2  && (cnt_q == CNT_LAST);
    assign commitLo = (state_q == WAIT_LO) && !s2 && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE_LO: begin
                if (s2) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (commitHi) begin
                    state_d = IDLE_HI;
                    dout_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!s2) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s2) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (commitLo) begin
                    state_d = IDLE_LO;
                    dout_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            dout_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;
    assign busy = (state_q == WAIT_HI) || (state_q == WAIT_LO);

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= commitHi;
            fall_q <= commitLo;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync_rstl.sv
// Directed bench for debounce_sync_rstl: reset, commit latency, glitch rejection,
// reset during WAIT and the RST_VAL=1 / STABLE_CNT=1 corner; honours DEBOUNCE_EDGE_EN.
module tb_debounce_sync_rstl;

`ifdef DEBOUNCE_EDGE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    logic clk;
    logic rstA, dinA, doutA, riseA, fallA, busyA;
    logic rstB, dinB, doutB, riseB, fallB, busyB;

    int vectorCount = 0;
    int missCount   = 0;

    debounce_sync_rstl #(
        .CNT_W(3), .STABLE_CNT(4), .RST_VAL(1'b0)
    ) dutA (
        .clk(clk), .rst(rstA), .din(dinA),
        .dout(doutA), .rise(riseA), .fall(fallA), .busy(busyA)
    );

    debounce_sync_rstl #(
        .CNT_W(2), .STABLE_CNT(1), .RST_VAL(1'b1)
    ) dutB (
        .clk(clk), .rst(rstB), .din(dinB),
        .dout(doutB), .rise(riseB), .fall(fallB), .busy(busyB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock edge with the given inputs held across it; outputs sampled 1ns later.
    task automatic applyStimulus(input logic rA, input logic dA, input logic rB, input logic dB);
        rstA = rA;
        dinA = dA;
        rstB = rB;
        dinB = dB;
        @(posedge clk);
        #1;
    endtask

    task automatic checkA(input string tag, input logic eDout, input logic eRise,
                          input logic eFall, input logic eBusy);
        checkOutput({tag, " doutA"}, 32'(doutA), 32'(eDout));
        checkOutput({tag, " riseA"}, 32'(riseA), 32'(eRise));
        checkOutput({tag, " fallA"}, 32'(fallA), 32'(eFall));
        checkOutput({tag, " busyA"}, 32'(busyA), 32'(eBusy));
    endtask

    task automatic checkB(input string tag, input logic eDout, input logic eRise,
                          input logic eFall, input logic eBusy);
        checkOutput({tag, " doutB"}, 32'(doutB), 32'(eDout));
        checkOutput({tag, " riseB"}, 32'(riseB), 32'(eRise));
        checkOutput({tag, " fallB"}, 32'(fallB), 32'(eFall));
        checkOutput({tag, " busyB"}, 32'(busyB), 32'(eBusy));
    endtask

    initial begin
        rstA = 1'b0; dinA = 1'b1;
        rstB = 1'b0; dinB = 1'b0;
        $display("[TB] start, EDGE_EN=%0d", EDGE_EN);

        // Reset held three edges with din high
        for (int e = 1; e <= 3; e++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkA($sformatf("rst e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // din high after release: busy edges 3..6, commit at edge 7
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkA($sformatf("up e%0d", e), e >= 7, EDGE_EN && e == 7, 1'b0,
                   e >= 3 && e <= 6);
        end

        // din low: fall at edge 7
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkA($sformatf("down e%0d", e), e < 7, 1'b0, EDGE_EN && e == 7,
                   e >= 3 && e <= 6);
        end

        // Two-cycle glitch: busy on edges 3 and 4 only, no output change
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(1'b1, e <= 2, 1'b0, 1'b0);
            checkA($sformatf("glitch e%0d", e), 1'b0, 1'b0, 1'b0, e == 3 || e == 4);
        end

        // Reset asserted in WAIT_HI once cnt reaches 2 (after edge 5)
        for (int e = 1; e <= 5; e++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkA($sformatf("pre e%0d", e), 1'b0, 1'b0, 1'b0, e >= 3);
        end
        checkOutput("cnt before reset", 32'(dutA.cnt_q), 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkA("midwait rst", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("cnt after reset", 32'(dutA.cnt_q), 32'd0);
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkA($sformatf("restart e%0d", e), e >= 7, EDGE_EN && e == 7, 1'b0,
                   e >= 3 && e <= 6);
        end

        // RST_VAL=1, STABLE_CNT=1 instance
        for (int e = 1; e <= 2; e++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkB($sformatf("B rst e%0d", e), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int e = 1; e <= 5; e++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
            checkB($sformatf("B down e%0d", e), e < 4, 1'b0, EDGE_EN && e == 4, e == 3);
        end
        for (int e = 1; e <= 5; e++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
            checkB($sformatf("B up e%0d", e), e >= 4, EDGE_EN && e == 4, 1'b0, e == 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
